// File: rtl/rom_load_ctl.sv
// Cartridge ROM sequencer: the HPS loader writes the image, short images are
// mirror-filled up to FILL_LIMIT bytes, and the A2601 core is held in reset before RUN.
module rom_load_ctl #(
  parameter int unsigned FILL_LIMIT  = 4096,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  mem_dout,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic [16:0] rom_size,
  output logic        img_valid,
  output logic        core_reset
);

  localparam logic [16:0] FILL_SIZE = 17'(FILL_LIMIT);
  localparam logic [15:0] FILL_LAST = 16'(FILL_LIMIT - 1);
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_LOAD,
    S_FILL_RD,
    S_FILL_WAIT,
    S_FILL_WR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [16:0] size_q = '0;
  logic [16:0] size_d;
  logic        valid_q = 1'b0;
  logic        valid_d;
  logic        old_dl_q;
  logic        wr_we_q, wr_we_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        dl_rise;
  logic        dl_fall;
  logic        load_hit;
  logic [16:0] wr_end;

  assign dl_rise  = ioctl_download & ~old_dl_q;
  assign dl_fall  = ~ioctl_download & old_dl_q;
  assign load_hit = ioctl_wr & (ioctl_addr[24:16] == '0);
  assign wr_end   = {1'b0, ioctl_addr[15:0]} + 17'd1;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    src_d     = src_q;
    dst_d     = dst_q;
    size_d    = size_q;
    valid_d   = valid_q;
    wr_we_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (dl_rise) begin
      state_d = S_LOAD;
      size_d  = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          // Loaded with HOLD_CYCLES on entry, so core_reset spans exactly that many clocks.
          if (hold_q <= 16'd1) state_d = S_RUN;
          else                 hold_d  = hold_q - 16'd1;
        end
        S_RUN: ;
        S_LOAD: begin
          if (load_hit) begin
            wr_we_d   = 1'b1;
            wr_addr_d = ioctl_addr[15:0];
            wr_data_d = ioctl_dout;
            if (wr_end > size_q) size_d = wr_end;
          end
          if (dl_fall) begin
            if (size_d == '0) begin
              state_d = S_HOLD;
              hold_d  = HOLD_INIT;
            end else if (size_d >= FILL_SIZE) begin
              state_d = S_HOLD;
              hold_d  = HOLD_INIT;
              valid_d = 1'b1;
            end else begin
              src_d   = '0;
              dst_d   = size_d[15:0];
              state_d = S_FILL_RD;
            end
          end
        end
        S_FILL_RD:   state_d = S_FILL_WAIT;
        S_FILL_WAIT: state_d = S_FILL_WR;
        S_FILL_WR: begin
          // Wrap at the image end so non-power-of-two images repeat whole.
          src_d = ({1'b0, src_q} == size_q - 17'd1) ? '0 : src_q + 16'd1;
          if (dst_q == FILL_LAST) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
            valid_d = 1'b1;
          end else begin
            dst_d   = dst_q + 16'd1;
            state_d = S_FILL_RD;
          end
        end
        default: begin
          state_d = S_HOLD;
          hold_d  = HOLD_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_HOLD;
      hold_q   <= HOLD_INIT;
      old_dl_q <= 1'b0;
      wr_we_q  <= 1'b0;
      if (state_q inside {S_LOAD, S_FILL_RD, S_FILL_WAIT, S_FILL_WR})
        valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      size_q    <= size_d;
      valid_q   <= valid_d;
      old_dl_q  <= ioctl_download;
      wr_we_q   <= wr_we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = wr_data_q;
    mem_we   = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        mem_addr = wr_addr_q;
        mem_we   = wr_we_q;
      end
      S_FILL_RD, S_FILL_WAIT: mem_addr = src_q;
      S_FILL_WR: begin
        mem_addr = dst_q;
        mem_din  = mem_dout;
        mem_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign rom_size   = size_q;
  assign img_valid  = valid_q;
  assign core_reset = (state_q != S_RUN);

endmodule

// File: tb/tb_rom_load_ctl.sv
// Directed bench for rom_load_ctl with a behavioural single-port ROM array on the memory port.
module tb_rom_load_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] cpu_addr;
  logic [7:0]  mem_dout;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [16:0] rom_size;
  logic        img_valid;
  logic        core_reset;

  logic [7:0] mem [0:65535];

  int total = 0;
  int bad   = 0;

  rom_load_ctl #(.FILL_LIMIT(4096), .HOLD_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .cpu_addr(cpu_addr),
    .mem_dout(mem_dout), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .rom_size(rom_size), .img_valid(img_valid), .core_reset(core_reset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int n, input logic [7:0] pat);
    ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < n; a++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'(a) ^ pat;
      tick();
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic drop_and_run(output int fills, output int hold, output bit done);
    ioctl_download = 1'b0;
    tick();
    fills = 0; hold = 0; done = 1'b0;
    for (int i = 0; i < 14000; i++) begin
      if (mem_we) begin fills++; hold = 0; end
      else if (core_reset) hold++;
      else begin done = 1'b1; break; end
      tick();
    end
  endtask

  task automatic count_hold(output int h, output bit we_seen);
    h = 0; we_seen = 1'b0;
    while (core_reset === 1'b1 && h < 200) begin
      if (mem_we) we_seen = 1'b1;
      h++;
      tick();
    end
  endtask

  task automatic test_reset();
    int h; bit we;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    cpu_addr = 16'h0ABC;
    tick(); tick();
    total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got %0h want 1", core_reset); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got %0h want 0", mem_we); end
    total++; if (rom_size !== 17'd0) begin bad++; $display("FAIL rst_rom_size got %0d want 0", rom_size); end
    total++; if (img_valid !== 1'b0) begin bad++; $display("FAIL rst_img_valid got %0h want 0", img_valid); end
    total++; if (mem_addr !== 16'h0ABC) begin bad++; $display("FAIL rst_mem_addr got %0h want abc", mem_addr); end
    reset = 1'b0;
    count_hold(h, we);
    total++; if (h !== 16) begin bad++; $display("FAIL rst_hold_len got %0d want 16", h); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_hold_we got %0h want 0", we); end
    cpu_addr = 16'h1357;
    #1;
    total++; if (mem_addr !== 16'h1357) begin bad++; $display("FAIL run_passthru got %0h want 1357", mem_addr); end
  endtask

  task automatic test_load_2048();
    int f, h; bit d;
    do_load(2048, 8'h00);
    total++; if (mem_we !== 1'b1 || mem_addr !== 16'h07FF) begin bad++; $display("FAIL l2k_last_wr got we=%0h addr=%0h want we=1 addr=7ff", mem_we, mem_addr); end
    total++; if (rom_size !== 17'd2048) begin bad++; $display("FAIL l2k_size got %0d want 2048", rom_size); end
    total++; if (img_valid !== 1'b0) begin bad++; $display("FAIL l2k_valid_load got %0h want 0", img_valid); end
    drop_and_run(f, h, d);
    total++; if (d !== 1'b1) begin bad++; $display("FAIL l2k_timeout got %0h want 1", d); end
    total++; if (f !== 2048) begin bad++; $display("FAIL l2k_fills got %0d want 2048", f); end
    total++; if (h !== 16) begin bad++; $display("FAIL l2k_hold got %0d want 16", h); end
    total++; if (img_valid !== 1'b1) begin bad++; $display("FAIL l2k_valid got %0h want 1", img_valid); end
    total++; if (mem[16'h0FFF] !== 8'hFF) begin bad++; $display("FAIL l2k_mem_fff got %0h want ff", mem[16'h0FFF]); end
    total++; if (mem[16'h0800] !== 8'h00) begin bad++; $display("FAIL l2k_mem_800 got %0h want 00", mem[16'h0800]); end
    total++; if (mem[16'h09A5] !== 8'hA5) begin bad++; $display("FAIL l2k_mem_9a5 got %0h want a5", mem[16'h09A5]); end
  endtask

  task automatic test_load_3000();
    int f, h; bit d;
    do_load(3000, 8'h5A);
    // Rewrite a low address: size must track the maximum, not the last write.
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h5F;
    tick();
    ioctl_wr = 1'b0;
    total++; if (rom_size !== 17'd3000) begin bad++; $display("FAIL l3k_size_max got %0d want 3000", rom_size); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 16'd5) begin bad++; $display("FAIL l3k_rewr got we=%0h addr=%0h want we=1 addr=5", mem_we, mem_addr); end
    drop_and_run(f, h, d);
    total++; if (d !== 1'b1) begin bad++; $display("FAIL l3k_timeout got %0h want 1", d); end
    total++; if (f !== 1096) begin bad++; $display("FAIL l3k_fills got %0d want 1096", f); end
    total++; if (h !== 16) begin bad++; $display("FAIL l3k_hold got %0d want 16", h); end
    total++; if (mem[3000] !== 8'h5A) begin bad++; $display("FAIL l3k_mem_3000 got %0h want 5a", mem[3000]); end
    total++; if (mem[4095] !== 8'h1D) begin bad++; $display("FAIL l3k_mem_4095 got %0h want 1d", mem[4095]); end
    total++; if (mem[2999] !== 8'hED) begin bad++; $display("FAIL l3k_mem_2999 got %0h want ed", mem[2999]); end
    total++; if (img_valid !== 1'b1) begin bad++; $display("FAIL l3k_valid got %0h want 1", img_valid); end
  endtask

  task automatic test_load_1000_wrap();
    int f, h; bit d;
    do_load(1000, 8'hA5);
    drop_and_run(f, h, d);
    total++; if (d !== 1'b1) begin bad++; $display("FAIL l1k_timeout got %0h want 1", d); end
    total++; if (f !== 3096) begin bad++; $display("FAIL l1k_fills got %0d want 3096", f); end
    total++; if (rom_size !== 17'd1000) begin bad++; $display("FAIL l1k_size got %0d want 1000", rom_size); end
    total++; if (mem[1000] !== 8'hA5) begin bad++; $display("FAIL l1k_mem_1000 got %0h want a5", mem[1000]); end
    total++; if (mem[1999] !== 8'h42) begin bad++; $display("FAIL l1k_mem_1999 got %0h want 42", mem[1999]); end
    total++; if (mem[2000] !== 8'hA5) begin bad++; $display("FAIL l1k_mem_2000 got %0h want a5", mem[2000]); end
    total++; if (mem[4095] !== 8'hFA) begin bad++; $display("FAIL l1k_mem_4095 got %0h want fa", mem[4095]); end
  endtask

  task automatic test_load_8192_oob();
    int h; bit we;
    cpu_addr = 16'hBEEF;
    do_load(8192, 8'h00);
    total++; if (rom_size !== 17'd8192) begin bad++; $display("FAIL l8k_size got %0d want 8192", rom_size); end
    ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'h77;
    tick();
    ioctl_wr = 1'b0;
    tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL oob_we got %0h want 0", mem_we); end
    total++; if (rom_size !== 17'd8192) begin bad++; $display("FAIL oob_size got %0d want 8192", rom_size); end
    ioctl_download = 1'b0;
    tick();
    total++; if (mem_addr !== 16'hBEEF || core_reset !== 1'b1) begin bad++; $display("FAIL l8k_hold_entry got addr=%0h rst=%0h want addr=beef rst=1", mem_addr, core_reset); end
    count_hold(h, we);
    total++; if (h !== 16) begin bad++; $display("FAIL l8k_hold got %0d want 16", h); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL l8k_fill_we got %0h want 0", we); end
    total++; if (img_valid !== 1'b1) begin bad++; $display("FAIL l8k_valid got %0h want 1", img_valid); end
    total++; if (mem[0] !== 8'h00) begin bad++; $display("FAIL oob_mem0 got %0h want 00", mem[0]); end
  endtask

  task automatic test_reset_in_run();
    int h; bit we;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (img_valid !== 1'b1) begin bad++; $display("FAIL rrun_valid got %0h want 1", img_valid); end
    total++; if (rom_size !== 17'd8192) begin bad++; $display("FAIL rrun_size got %0d want 8192", rom_size); end
    count_hold(h, we);
    total++; if (h !== 16) begin bad++; $display("FAIL rrun_hold got %0d want 16", h); end
  endtask

  task automatic test_reset_mid_fill();
    int h; bit we;
    do_load(100, 8'h3C);
    ioctl_download = 1'b0;
    repeat (30) tick();
    total++; if (core_reset !== 1'b1 || img_valid !== 1'b0) begin bad++; $display("FAIL mfill_busy got rst=%0h valid=%0h want rst=1 valid=0", core_reset, img_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_addr = 16'h4242;
    #1;
    total++; if (img_valid !== 1'b0) begin bad++; $display("FAIL mfill_valid got %0h want 0", img_valid); end
    total++; if (mem_addr !== 16'h4242) begin bad++; $display("FAIL mfill_addr got %0h want 4242", mem_addr); end
    total++; if (rom_size !== 17'd100) begin bad++; $display("FAIL mfill_size got %0d want 100", rom_size); end
    count_hold(h, we);
    total++; if (h !== 16) begin bad++; $display("FAIL mfill_hold got %0d want 16", h); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL mfill_we got %0h want 0", we); end
    cpu_addr = 16'hC0DE;
    #1;
    total++; if (mem_addr !== 16'hC0DE) begin bad++; $display("FAIL mfill_run_addr got %0h want c0de", mem_addr); end
  endtask

  task automatic test_reset_with_rise();
    int h; bit we;
    cpu_addr = 16'h1234;
    reset = 1'b1; ioctl_download = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (mem_addr !== 16'h1234 || core_reset !== 1'b1) begin bad++; $display("FAIL rrise_hold got addr=%0h rst=%0h want addr=1234 rst=1", mem_addr, core_reset); end
    total++; if (rom_size !== 17'd100) begin bad++; $display("FAIL rrise_size_kept got %0d want 100", rom_size); end
    tick();
    total++; if (rom_size !== 17'd0) begin bad++; $display("FAIL rrise_size_clr got %0d want 0", rom_size); end
    total++; if (mem_addr !== 16'h0063) begin bad++; $display("FAIL rrise_load_addr got %0h want 63", mem_addr); end
    ioctl_download = 1'b0;
    tick();
    total++; if (img_valid !== 1'b0 || mem_addr !== 16'h1234) begin bad++; $display("FAIL empty_hold got valid=%0h addr=%0h want valid=0 addr=1234", img_valid, mem_addr); end
    count_hold(h, we);
    total++; if (h !== 16) begin bad++; $display("FAIL empty_hold_len got %0d want 16", h); end
    total++; if (core_reset !== 1'b0 || img_valid !== 1'b0) begin bad++; $display("FAIL empty_run got rst=%0h valid=%0h want rst=0 valid=0", core_reset, img_valid); end
  endtask

  initial begin
    test_reset();
    test_load_2048();
    test_load_3000();
    test_load_1000_wrap();
    test_load_8192_oob();
    test_reset_in_run();
    test_reset_mid_fill();
    test_reset_with_rise();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
